// File: rtl/led_pattern_gen.sv
// led_pattern_gen: per-channel LED driver with OFF, ON, BLINK and PWM modes.
// All channels share one clock, a common sync restart and a PLL-lock hold.
module led_pattern_gen #(
    parameter int NUM_CH = 4,
    parameter int DIV_W  = 26,
    parameter int PWM_W  = 8,
    localparam int CH_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic              clk_sys,
    input  logic              reset,
    input  logic              locked,
    input  logic              sync,
    input  logic              cfg_we,
    input  logic [CH_W-1:0]   cfg_ch,
    input  logic [1:0]        cfg_mode,
    input  logic [DIV_W-1:0]  cfg_period,
    input  logic [PWM_W-1:0]  cfg_duty,
    output logic [NUM_CH-1:0] led,
    output logic [NUM_CH-1:0] wrap
);

    typedef enum logic [1:0] {
        MODE_OFF   = 2'd0,
        MODE_ON    = 2'd1,
        MODE_BLINK = 2'd2,
        MODE_PWM   = 2'd3
    } mode_e;

    logic ch_ok;

    assign ch_ok = ({1'b0, cfg_ch} < (CH_W + 1)'(NUM_CH));

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        mode_e            mode_q;
        logic [DIV_W-1:0] period_q;
        logic [PWM_W-1:0] duty_q;
        logic [DIV_W-1:0] div_cnt;
        logic [PWM_W-1:0] pwm_cnt;
        logic             led_q;
        logic             wrap_q;
        logic             sel;
        logic [DIV_W-1:0] last;
        logic             div_hit;
        logic             pwm_hit;

        assign sel     = cfg_we && ch_ok && (cfg_ch == CH_W'(i));
        // Period 0 behaves like period 1: toggle every cycle.
        assign last    = (period_q == '0) ? '0
                                          : period_q - DIV_W'(1);
        assign div_hit = (div_cnt == last);
        assign pwm_hit = &pwm_cnt;

        always_ff @(posedge clk_sys) begin
            if (reset) begin
                mode_q   <= MODE_OFF;
                period_q <= '0;
                duty_q   <= '0;
            end else if (sel) begin
                mode_q   <= mode_e'(cfg_mode);
                period_q <= cfg_period;
                duty_q   <= cfg_duty;
            end
        end

        // A write to this channel wins over sync for that channel.
        always_ff @(posedge clk_sys) begin
            if (reset || !locked || sel) begin
                div_cnt <= '0;
                pwm_cnt <= '0;
                led_q   <= 1'b0;
                wrap_q  <= 1'b0;
            end else if (sync) begin
                div_cnt <= '0;
                pwm_cnt <= '0;
                wrap_q  <= 1'b0;
                if (mode_q == MODE_BLINK) begin
                    led_q <= 1'b0;
                end
            end else begin
                unique case (mode_q)
                    MODE_OFF: begin
                        div_cnt <= '0;
                        pwm_cnt <= '0;
                        led_q   <= 1'b0;
                        wrap_q  <= 1'b0;
                    end
                    MODE_ON: begin
                        div_cnt <= '0;
                        pwm_cnt <= '0;
                        led_q   <= 1'b1;
                        wrap_q  <= 1'b0;
                    end
                    MODE_BLINK: begin
                        pwm_cnt <= '0;
                        if (div_hit) begin
                            div_cnt <= '0;
                            led_q   <= ~led_q;
                            wrap_q  <= 1'b1;
                        end else begin
                            div_cnt <= div_cnt + DIV_W'(1);
                            wrap_q  <= 1'b0;
                        end
                    end
                    MODE_PWM: begin
                        div_cnt <= '0;
                        pwm_cnt <= pwm_cnt + PWM_W'(1);
                        led_q   <= (pwm_cnt < duty_q);
                        wrap_q  <= pwm_hit;
                    end
                endcase
            end
        end

        assign led[i]  = led_q;
        assign wrap[i] = wrap_q;
    end

endmodule
